dmem_responder: RTL and testbench

// - Data-memory responder for the pipelined core's MEMORY_ACCESS stage: the slave end of the core's load/store port.
// - Accepts one load/store request via valid/ready and applies WAIT_STATES cycles of latency.
// - Returns one response via valid/ready: read data, or a write acknowledge, plus an error flag.
// - Handles byte/half/word sizing from funct3: store byte-lane writes, load sign/zero extension, misalign and range errors.

---
 rtl/riscv_mem_pkg.sv | 26 ++
 rtl/mem_lane_align.sv | 49 ++++
 rtl/dmem_responder.sv | 126 ++++++++++++
 tb/tb_dmem_responder.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/riscv_mem_pkg.sv
// Shared definitions for the core's data-memory port: size codes, responder
// states and the latched request record.
package riscv_mem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} dmem_state_t;

    typedef struct packed {
        logic        we;
        logic [2:0]  funct3;
        logic [31:0] addr;
        logic [31:0] wdata;
    } mem_req_t;

    // Unsigned loads have no store counterpart, so 1xx with we=1 is illegal too.
    function automatic logic illegal_size(input logic we, input logic [2:0] funct3);
        return (funct3 == 3'b011) || (funct3 == 3'b110) ||
               (funct3 == 3'b111) || (funct3[2] && we);
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering between a 32-bit memory word and the core's
// right-aligned store/load data, plus the natural-alignment check.
module mem_lane_align
    import riscv_mem_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rword_i,
    output logic [3:0]  be_o,
    output logic [31:0] wword_o,
    output logic        misalign_o,
    output logic [31:0] rdata_o
);

    logic [31:0] rshift;

    // Store data is replicated across lanes so the byte enables alone pick the target.
    always_comb begin
        be_o       = 4'b0000;
        wword_o    = 32'h0;
        misalign_o = 1'b0;
        rdata_o    = 32'h0;
        rshift     = rword_i >> {addr_lo_i, 3'b000};
        case (funct3_i)
            F3_B, F3_BU: begin
                be_o    = 4'b0001 << addr_lo_i;
                wword_o = {4{wdata_i[7:0]}};
                rdata_o = (funct3_i == F3_B) ? {{24{rshift[7]}}, rshift[7:0]}
                                             : {24'h0, rshift[7:0]};
            end
            F3_H, F3_HU: begin
                misalign_o = addr_lo_i[0];
                be_o       = 4'b0011 << {addr_lo_i[1], 1'b0};
                wword_o    = {2{wdata_i[15:0]}};
                rdata_o    = (funct3_i == F3_H) ? {{16{rshift[15]}}, rshift[15:0]}
                                                : {16'h0, rshift[15:0]};
            end
            F3_W: begin
                misalign_o = (addr_lo_i != 2'b00);
                be_o       = 4'b1111;
                wword_o    = wdata_i;
                rdata_o    = rshift;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory slave for the MEMORY_ACCESS stage: one request at a time,
// fixed wait-state latency, byte-enable storage and a held response.
module dmem_responder
    import riscv_mem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned WAIT_STATES = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h0
)(
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [2:0]  req_funct3_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_rdata_o,
    output logic        rsp_err_o
);

    localparam int          AW   = $clog2(DEPTH_WORDS);
    localparam logic [32:0] SPAN = 33'(DEPTH_WORDS) << 2;

    dmem_state_t state_q;
    mem_req_t    req_q;
    logic [3:0]  cnt_q;
    logic        req_ready_q;
    logic        rsp_valid_q;
    logic [31:0] rsp_rdata_q;
    logic        rsp_err_q;

    logic [31:0]   mem [DEPTH_WORDS];
    logic [31:0]   offset;
    logic [AW-1:0] word_idx;
    logic          in_range;
    logic [31:0]   rword;
    logic [3:0]    be;
    logic [31:0]   wword;
    logic          misalign;
    logic [31:0]   load_data;
    logic          access_err;
    logic          access_now;
    logic          do_write;

    // Subtracting the base wraps addresses below it to huge offsets, so one compare covers both ends.
    assign offset     = req_q.addr - BASE_ADDR;
    assign in_range   = ({1'b0, offset} < SPAN);
    assign word_idx   = offset[AW+1:2];
    assign rword      = mem[word_idx];
    assign access_err = misalign || !in_range || illegal_size(req_q.we, req_q.funct3);
    assign access_now = (state_q == WAIT) && (cnt_q == 4'd0);
    assign do_write   = access_now && req_q.we && !access_err;

    mem_lane_align u_align (
        .funct3_i   (req_q.funct3),
        .addr_lo_i  (offset[1:0]),
        .wdata_i    (req_q.wdata),
        .rword_i    (rword),
        .be_o       (be),
        .wword_o    (wword),
        .misalign_o (misalign),
        .rdata_o    (load_data)
    );

    always_ff @(posedge clk_i) begin
        if (do_write) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[word_idx][8*i +: 8] <= wword[8*i +: 8];
            end
        end
    end

    // WAIT runs down from WAIT_STATES and performs the access on the count of zero.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q     <= IDLE;
            req_q       <= '0;
            cnt_q       <= 4'd0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'h0;
            rsp_err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid_i) begin
                        req_q       <= '{we: req_we_i, funct3: req_funct3_i,
                                         addr: req_addr_i, wdata: req_wdata_i};
                        cnt_q       <= 4'(WAIT_STATES);
                        req_ready_q <= 1'b0;
                        state_q     <= WAIT;
                    end
                end
                WAIT: begin
                    if (access_now) begin
                        state_q     <= RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= access_err;
                        rsp_rdata_q <= (access_err || req_q.we) ? 32'h0 : load_data;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready_i) begin
                        state_q     <= IDLE;
                        req_ready_q <= 1'b1;
                        rsp_valid_q <= 1'b0;
                        rsp_rdata_q <= 32'h0;
                        rsp_err_q   <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_ready_o = req_ready_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_rdata_o = rsp_rdata_q;
    assign rsp_err_o   = rsp_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder with WAIT_STATES=2 and a 4 KiB array at address 0.
module tb_dmem_responder;

    logic        clk;
    logic        resetN;
    logic        reqValid;
    logic        reqReady;
    logic        reqWe;
    logic [2:0]  reqFunct3;
    logic [31:0] reqAddr;
    logic [31:0] reqWdata;
    logic        rspValid;
    logic        rspReady;
    logic [31:0] rspRdata;
    logic        rspErr;

    int totalChecks = 0;
    int passChecks  = 0;

    dmem_responder #(
        .DEPTH_WORDS (1024),
        .WAIT_STATES (2),
        .BASE_ADDR   (32'h0)
    ) dut (
        .clk_i        (clk),
        .reset_i      (resetN),
        .req_valid_i  (reqValid),
        .req_ready_o  (reqReady),
        .req_we_i     (reqWe),
        .req_funct3_i (reqFunct3),
        .req_addr_i   (reqAddr),
        .req_wdata_i  (reqWdata),
        .rsp_valid_o  (rspValid),
        .rsp_ready_i  (rspReady),
        .rsp_rdata_o  (rspRdata),
        .rsp_err_o    (rspErr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        totalChecks++;
        assert (obs === exp) passChecks++;
        else $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
    endtask

    // One full transaction: accept, latency of WAIT_STATES+1, optional backpressure, handshake.
    task automatic applyStimulus(input string tag, input logic we, input logic [2:0] f3,
                                 input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [31:0] expRdata, input logic expErr,
                                 input int holdCycles);
        int cycles;
        logic seen;
        @(negedge clk);
        reqValid  = 1'b1;
        reqWe     = we;
        reqFunct3 = f3;
        reqAddr   = addr;
        reqWdata  = wdata;
        rspReady  = 1'b0;
        checkOutput({tag, "_reqReady"}, 32'(reqReady), 32'd1);
        @(posedge clk);
        #1;
        reqValid = 1'b0;
        cycles = 0;
        seen   = 1'b0;
        while (!seen && cycles < 40) begin
            @(posedge clk);
            #1;
            cycles++;
            seen = rspValid;
        end
        if (!seen) begin
            totalChecks++;
            $error("[TB] FAIL %s_timeout: rsp_valid_o observed=0 expected=1", tag);
            return;
        end
        checkOutput({tag, "_latency"}, 32'(cycles), 32'd3);
        checkOutput({tag, "_rdata"}, rspRdata, expRdata);
        checkOutput({tag, "_err"}, 32'(rspErr), 32'(expErr));
        for (int i = 0; i < holdCycles; i++) begin
            @(posedge clk);
            #1;
            checkOutput({tag, "_holdValid"}, 32'(rspValid), 32'd1);
            checkOutput({tag, "_holdRdata"}, rspRdata, expRdata);
            checkOutput({tag, "_holdReqReady"}, 32'(reqReady), 32'd0);
        end
        @(negedge clk);
        rspReady = 1'b1;
        @(posedge clk);
        #1;
        rspReady = 1'b0;
        checkOutput({tag, "_doneValid"}, 32'(rspValid), 32'd0);
        checkOutput({tag, "_doneReqReady"}, 32'(reqReady), 32'd1);
    endtask

    initial begin
        resetN    = 1'b0;
        reqValid  = 1'b0;
        reqWe     = 1'b0;
        reqFunct3 = 3'b000;
        reqAddr   = 32'h0;
        reqWdata  = 32'h0;
        rspReady  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_reqReady", 32'(reqReady), 32'd1);
        checkOutput("reset_rspValid", 32'(rspValid), 32'd0);
        checkOutput("reset_rdata", rspRdata, 32'h0);
        checkOutput("reset_err", 32'(rspErr), 32'd0);
        @(negedge clk);
        resetN = 1'b1;

        applyStimulus("sw_dead",   1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 0);
        applyStimulus("lw_dead",   1'b0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 0);

        applyStimulus("sw_base",   1'b1, 3'b010, 32'h10, 32'h11223344, 32'h0, 1'b0, 0);
        applyStimulus("sb_lane3",  1'b1, 3'b000, 32'h13, 32'h00000080, 32'h0, 1'b0, 0);
        applyStimulus("lw_afterSb",1'b0, 3'b010, 32'h10, 32'h0, 32'h80223344, 1'b0, 0);
        applyStimulus("lb_13",     1'b0, 3'b000, 32'h13, 32'h0, 32'hFFFFFF80, 1'b0, 0);
        applyStimulus("lbu_13",    1'b0, 3'b100, 32'h13, 32'h0, 32'h00000080, 1'b0, 0);
        applyStimulus("lh_12",     1'b0, 3'b001, 32'h12, 32'h0, 32'hFFFF8022, 1'b0, 0);
        applyStimulus("lhu_10",    1'b0, 3'b101, 32'h10, 32'h0, 32'h00003344, 1'b0, 0);
        applyStimulus("lb_11",     1'b0, 3'b000, 32'h11, 32'h0, 32'h00000033, 1'b0, 0);

        applyStimulus("lw_mis",    1'b0, 3'b010, 32'h12, 32'h0, 32'h0, 1'b1, 0);
        applyStimulus("sh_mis",    1'b1, 3'b001, 32'h11, 32'h0000AAAA, 32'h0, 1'b1, 0);
        applyStimulus("lw_noMis",  1'b0, 3'b010, 32'h10, 32'h0, 32'h80223344, 1'b0, 0);
        applyStimulus("sh_hi",     1'b1, 3'b001, 32'h12, 32'h0000BEEF, 32'h0, 1'b0, 0);
        applyStimulus("lw_afterSh",1'b0, 3'b010, 32'h10, 32'h0, 32'hBEEF3344, 1'b0, 0);

        applyStimulus("lw_oor",    1'b0, 3'b010, 32'h1000, 32'h0, 32'h0, 1'b1, 0);
        applyStimulus("sw_top",    1'b1, 3'b010, 32'hFFC, 32'hCAFEF00D, 32'h0, 1'b0, 0);
        applyStimulus("lw_top",    1'b0, 3'b010, 32'hFFC, 32'h0, 32'hCAFEF00D, 1'b0, 0);
        applyStimulus("f3_011",    1'b0, 3'b011, 32'h10, 32'h0, 32'h0, 1'b1, 0);
        applyStimulus("st_f3_100", 1'b1, 3'b100, 32'h10, 32'h0, 32'h0, 1'b1, 0);
        applyStimulus("lw_unhurt", 1'b0, 3'b010, 32'h10, 32'h0, 32'hBEEF3344, 1'b0, 0);

        applyStimulus("bp_lw",     1'b0, 3'b010, 32'h10, 32'h0, 32'hBEEF3344, 1'b0, 5);

        applyStimulus("sw_zero20", 1'b1, 3'b010, 32'h20, 32'h0, 32'h0, 1'b0, 0);
        @(negedge clk);
        reqValid  = 1'b1;
        reqWe     = 1'b1;
        reqFunct3 = 3'b010;
        reqAddr   = 32'h20;
        reqWdata  = 32'h12345678;
        @(posedge clk);
        #1;
        reqValid = 1'b0;
        checkOutput("midWait_busy", 32'(reqReady), 32'd0);
        @(negedge clk);
        resetN = 1'b0;
        #1;
        checkOutput("midReset_reqReady", 32'(reqReady), 32'd1);
        checkOutput("midReset_rspValid", 32'(rspValid), 32'd0);
        checkOutput("midReset_rdata", rspRdata, 32'h0);
        checkOutput("midReset_err", 32'(rspErr), 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        resetN = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        checkOutput("postReset_rspValid", 32'(rspValid), 32'd0);
        applyStimulus("lw_20",     1'b0, 3'b010, 32'h20, 32'h0, 32'h0, 1'b0, 0);
        applyStimulus("lw_survive",1'b0, 3'b010, 32'h10, 32'h0, 32'hBEEF3344, 1'b0, 0);

        $display("%0d/%0d checks passed", passChecks, totalChecks);
        $finish;
    end

endmodule
